// File: rtl/wavegen_pkg.sv
// ============================================================================
// wavegen_pkg
//   Shared sample type and analyzer state encoding for the wavegen blocks.
//   Rev 1.0
// ============================================================================
`default_nettype none

package wavegen_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/zero_cross_detect.sv
// ============================================================================
// zero_cross_detect
//   Remembers the sign of the last accepted sample and flags rising crossings.
//   Rev 1.0
// ============================================================================
`default_nettype none

module zero_cross_detect
  import wavegen_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  sample_t sample_i,
  output logic    rise_o
);

  logic prev_neg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_neg_q <= 1'b0;
    end else if (valid_i) begin
      prev_neg_q <= sample_i[SAMPLE_W-1];
    end
  end

  // Zero counts as non-negative, so -1 -> 0 is a crossing.
  assign rise_o = valid_i & prev_neg_q & ~sample_i[SAMPLE_W-1];

endmodule

`default_nettype wire

// File: rtl/sine_period_analyzer.sv
// ============================================================================
// sine_period_analyzer
//   Measures period, peaks and peak-to-peak span between rising zero crossings.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sine_period_analyzer
  import wavegen_pkg::*;
#(
  parameter int MAX_PERIOD = 255,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       peak_pos,
  output logic [7:0]       peak_neg,
  output logic [8:0]       p2p,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W:0] c_MAX_PERIOD = (CNT_W+1)'(MAX_PERIOD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          max_q, max_d;
  sample_t          min_q, min_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [7:0]       peak_pos_q, peak_pos_d;
  logic [7:0]       peak_neg_q, peak_neg_d;
  logic [8:0]       p2p_q, p2p_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             primed_q, primed_d;

  sample_t          w_sample;
  logic             w_rise;
  logic [CNT_W:0]   w_cnt_inc;
  logic [8:0]       w_span;

  assign w_sample  = sample_t'(sample);
  assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign w_span    = {max_q[SAMPLE_W-1], max_q} - {min_q[SAMPLE_W-1], min_q};

  zero_cross_detect u_zcd (
    .clk     (clk),
    .rst     (rst),
    .valid_i (sample_valid),
    .sample_i(w_sample),
    .rise_o  (w_rise)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    max_d        = max_q;
    min_d        = min_q;
    period_d     = period_q;
    peak_pos_d   = peak_pos_q;
    peak_neg_d   = peak_neg_q;
    p2p_d        = p2p_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    locked_d     = locked_q;
    primed_d     = primed_q;

    if (sample_valid) begin
      case (state_q)
        SEEK: begin
          if (w_sample[SAMPLE_W-1]) state_d = ARMED;
        end
        ARMED: begin
          if (w_rise) begin
            state_d = MEASURE;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            max_d   = w_sample;
            min_d   = w_sample;
          end
        end
        MEASURE: begin
          // A crossing is checked first so it wins over a coincident timeout.
          if (w_rise) begin
            period_d     = cnt_q;
            peak_pos_d   = max_q;
            peak_neg_d   = min_q;
            p2p_d        = w_span;
            meas_valid_d = 1'b1;
            locked_d     = primed_q && (cnt_q == period_q);
            primed_d     = 1'b1;
            cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
            max_d        = w_sample;
            min_d        = w_sample;
          end else begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
            if (w_sample > max_q) max_d = w_sample;
            if (w_sample < min_q) min_d = w_sample;
            if (w_cnt_inc == c_MAX_PERIOD) begin
              timeout_d = 1'b1;
              locked_d  = 1'b0;
              primed_d  = 1'b0;
              state_d   = SEEK;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEEK;
      cnt_q        <= '0;
      max_q        <= '0;
      min_q        <= '0;
      period_q     <= '0;
      peak_pos_q   <= '0;
      peak_neg_q   <= '0;
      p2p_q        <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      min_q        <= min_d;
      period_q     <= period_d;
      peak_pos_q   <= peak_pos_d;
      peak_neg_q   <= peak_neg_d;
      p2p_q        <= p2p_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      primed_q     <= primed_d;
    end
  end

  assign period     = period_q;
  assign peak_pos   = peak_pos_q;
  assign peak_neg   = peak_neg_q;
  assign p2p        = p2p_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sine_period_analyzer.sv
// ============================================================================
// tb_sine_period_analyzer
//   Reference-model bench for sine_period_analyzer with directed and random phases.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_sine_period_analyzer;

  localparam int MAXP = 16;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample = 8'h00;
  logic [CW-1:0] period;
  logic [7:0]    peak_pos, peak_neg;
  logic [8:0]    p2p;
  logic          meas_valid, locked, timeout;

  always #5 clk = ~clk;

  sine_period_analyzer #(.MAX_PERIOD(MAXP), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .period      (period),
    .peak_pos    (peak_pos),
    .peak_neg    (peak_neg),
    .p2p         (p2p),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  // Reference model: the current cycle's samples are held as a list and the
  // results are computed from that list when the cycle closes.
  int       m_mode;        // 0 waiting for a negative, 1 waiting for a crossing, 2 measuring
  bit       m_prevneg;
  int       m_hist[$];
  bit       m_primed;
  logic [CW-1:0] nx_period, exp_period;
  logic [7:0]    nx_pp, nx_pn, exp_pp, exp_pn;
  logic [8:0]    nx_p2p, exp_p2p;
  bit            nx_mv, nx_lock, nx_to, exp_mv, exp_lock, exp_to;

  task automatic model(input bit r, input bit v, input logic [7:0] s);
    int  sn, mx, mn, p;
    bit  neg, rise;
    nx_mv = 0;
    nx_to = 0;
    if (r) begin
      m_mode = 0; m_prevneg = 0; m_hist.delete(); m_primed = 0;
      nx_period = '0; nx_pp = '0; nx_pn = '0; nx_p2p = '0; nx_lock = 0;
      return;
    end
    if (!v) return;
    sn   = int'($signed(s));
    neg  = (sn < 0);
    rise = m_prevneg && !neg;
    if (m_mode == 0) begin
      if (neg) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2;
        m_hist.delete();
        m_hist.push_back(sn);
      end
    end else begin
      if (rise) begin
        p  = m_hist.size();
        mx = -1000; mn = 1000;
        foreach (m_hist[i]) begin
          if (m_hist[i] > mx) mx = m_hist[i];
          if (m_hist[i] < mn) mn = m_hist[i];
        end
        nx_lock   = m_primed && (p == int'(nx_period));
        m_primed  = 1;
        nx_period = CW'(p);
        nx_pp     = 8'(mx);
        nx_pn     = 8'(mn);
        nx_p2p    = 9'(mx - mn);
        nx_mv     = 1;
        m_hist.delete();
        m_hist.push_back(sn);
      end else if (m_hist.size() + 1 == MAXP) begin
        nx_to    = 1;
        nx_lock  = 0;
        m_primed = 0;
        m_mode   = 0;
      end else begin
        m_hist.push_back(sn);
      end
    end
    m_prevneg = neg;
  endtask

  bit chk_en = 0;
  int cyc = 0, mv_cnt = 0, mv_last = 0, mv_gap = 0, to_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      check("period",     32'(period),     32'(exp_period));
      check("peak_pos",   32'(peak_pos),   32'(exp_pp));
      check("peak_neg",   32'(peak_neg),   32'(exp_pn));
      check("p2p",        32'(p2p),        32'(exp_p2p));
      check("meas_valid", 32'(meas_valid), 32'(exp_mv));
      check("locked",     32'(locked),     32'(exp_lock));
      check("timeout",    32'(timeout),    32'(exp_to));
      if (meas_valid) begin
        mv_cnt++;
        mv_gap  = cyc - mv_last;
        mv_last = cyc;
      end
      if (timeout) to_cnt++;
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] s);
    rst = r; sample_valid = v; sample = s;
    model(r, v, s);
    @(posedge clk);
    #1;
    exp_period = nx_period; exp_pp = nx_pp; exp_pn = nx_pn; exp_p2p = nx_p2p;
    exp_mv = nx_mv; exp_lock = nx_lock; exp_to = nx_to;
    chk_en = 1;
    @(negedge clk);
    #1;
  endtask

  logic [7:0] sine_seq [8];
  logic [7:0] sq4 [4];

  initial begin
    sine_seq = '{8'h00, 8'h5A, 8'h7F, 8'h5A, 8'h00, 8'hA6, 8'h81, 8'hA6};
    sq4      = '{8'h00, 8'h7F, 8'h00, 8'h81};

    step(1, 0, 8'h00);
    check("reset_period", 32'(period), 0);
    check("reset_p2p",    32'(p2p),    0);
    check("reset_locked", 32'(locked), 0);

    // Steady sine
    mv_cnt = 0;
    for (int k = 0; k < 32; k++) step(0, 1, sine_seq[k % 8]);
    check("steady_mv_count", 32'(mv_cnt), 2);
    check("steady_period",   32'(period), 8);
    check("steady_peak_pos", 32'(peak_pos), 32'h7F);
    check("steady_peak_neg", 32'(peak_neg), 32'h81);
    check("steady_p2p",      32'(p2p), 254);
    check("steady_locked",   32'(locked), 1);

    // Gapped valid
    mv_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(0, 1, sine_seq[k % 8]);
      step(0, 0, 8'($urandom));
    end
    check("gap_mv_count", 32'(mv_cnt), 4);
    check("gap_spacing",  32'(mv_gap), 16);
    check("gap_period",   32'(period), 8);
    check("gap_locked",   32'(locked), 1);

    // Period change
    for (int k = 0; k < 5; k++) step(0, 1, sq4[k % 4]);
    check("chg_period",   32'(period), 4);
    check("chg_unlocked", 32'(locked), 0);
    for (int k = 5; k < 13; k++) step(0, 1, sq4[k % 4]);
    check("chg_relocked", 32'(locked), 1);
    check("chg_period2",  32'(period), 4);

    // Timeout: negative, crossing, then constant positive
    to_cnt = 0;
    step(0, 1, 8'h81);
    step(0, 1, 8'h00);
    for (int k = 0; k < 14; k++) step(0, 1, 8'h10);
    check("to_not_yet", 32'(to_cnt), 0);
    step(0, 1, 8'h10);
    check("to_fired",  32'(to_cnt), 1);
    check("to_locked", 32'(locked), 0);
    check("to_period_held", 32'(period), 2);
    for (int k = 0; k < 20; k++) step(0, 1, 8'h10);
    check("to_once", 32'(to_cnt), 1);

    // Reset mid-cycle of a locked stream
    for (int k = 0; k < 29; k++) step(0, 1, sine_seq[k % 8]);
    check("rst_pre_locked", 32'(locked), 1);
    step(1, 1, sine_seq[5]);
    check("rst_period",   32'(period), 0);
    check("rst_peak_pos", 32'(peak_pos), 0);
    check("rst_locked",   32'(locked), 0);
    mv_cnt = 0;
    step(0, 1, sine_seq[6]);
    step(0, 1, sine_seq[7]);
    for (int k = 0; k < 8; k++) step(0, 1, sine_seq[k]);
    check("rst_no_early_mv", 32'(mv_cnt), 0);
    step(0, 1, sine_seq[0]);
    check("rst_first_mv",  32'(mv_cnt), 1);
    check("rst_period_new", 32'(period), 8);

    // Randomized square-ish waves of varying period, gaps and rare resets
    for (int it = 0; it < 80; it++) begin
      int p, negc, reps;
      p    = $urandom_range(2, 20);
      negc = $urandom_range(1, p - 1);
      reps = $urandom_range(1, 3);
      for (int rp = 0; rp < reps; rp++) begin
        for (int j = 0; j < p; j++) begin
          logic [7:0] s;
          s = (j < negc) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
          while ($urandom_range(0, 3) == 0) step(0, 0, 8'($urandom));
          step(($urandom_range(0, 149) == 0), 1, s);
        end
      end
    end

    // DC level then the -1 -> 0 edge
    step(1, 0, 8'h00);
    mv_cnt = 0; to_cnt = 0;
    for (int k = 0; k < 10; k++) step(0, 1, 8'h00);
    check("dc_no_mv", 32'(mv_cnt), 0);
    check("dc_no_to", 32'(to_cnt), 0);
    step(0, 1, 8'hFF);
    step(0, 1, 8'h00);
    step(0, 1, 8'hFF);
    step(0, 1, 8'h00);
    check("edge_mv",       32'(mv_cnt), 1);
    check("edge_period",   32'(period), 2);
    check("edge_peak_pos", 32'(peak_pos), 32'h00);
    check("edge_peak_neg", 32'(peak_neg), 32'hFF);
    check("edge_p2p",      32'(p2p), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
